// File: rtl/seqdet_rr_scheduler_pkg.sv
// Shared types for the round-robin sequence-detector scheduler: detector state
// encoding, controller states and the detector next-state function.
package seqdet_rr_scheduler_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_W   = 8;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        RESP  = 2'b10
    } ctrl_state_t;

    // Detector transition table; any 0 input returns the machine to S0.
    function automatic det_state_t det_next(input det_state_t s, input logic x);
        det_state_t n;
        n = S0;
        case (s)
            S0: n = x ? S1 : S0;
            S1: n = x ? S3 : S0;
            S2: n = x ? S2 : S0;
            S3: n = x ? S2 : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seqdet_rr_scheduler_if.sv
// Request/response bundle between the channel producers/consumer and the scheduler.
interface seqdet_rr_scheduler_if
    import seqdet_rr_scheduler_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int W   = DEF_W
);
    localparam int CHW = $clog2(NCH);
    localparam int CW  = $clog2(W + 1);

    logic [NCH-1:0]   req_valid;
    logic [NCH*W-1:0] req_data;
    logic [NCH-1:0]   req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [CHW-1:0]   resp_ch;
    logic [CW-1:0]    resp_count;
    logic             busy;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_ch, resp_count, busy
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_ch, resp_count, busy
    );

endinterface

// File: rtl/seqdet_rr_scheduler_core.sv
// Serial Mealy sequence detector: y pulses when a 0 arrives while not in S0.
module seqdet_core
    import seqdet_rr_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic y
);
    det_state_t state;

    // Clear wins over enable so a new job always starts from S0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S0;
        else if (clr)
            state <= S0;
        else if (en)
            state <= det_next(state, x);
    end

    assign y = !x && (state != S0);

endmodule

// File: rtl/seqdet_rr_scheduler.sv
// Round-robin front end that serialises one channel's word at a time through
// a shared sequence detector and returns {channel, pulse count}.
module seqdet_rr_scheduler
    import seqdet_rr_scheduler_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int W   = DEF_W
) (
    input logic clk,
    input logic rst,
    seqdet_rr_scheduler_if.slave bus
);
    localparam int CHW = $clog2(NCH);
    localparam int CW  = $clog2(W + 1);

    ctrl_state_t    state;
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] winner;
    logic           any_req;
    logic [NCH-1:0] grant_vec;
    logic [W-1:0]   word;
    logic [CW-1:0]  bit_idx;
    logic [CW-1:0]  cnt;
    logic [CHW-1:0] resp_ch;
    logic [CW-1:0]  resp_count;
    logic           resp_valid;
    logic           busy;
    logic           grant;
    logic           last_bit;
    logic           core_y;

    // Scan downward from the farthest offset so the nearest requester at or
    // after rr_ptr is the last one written and therefore wins.
    always_comb begin : pick
        int idx;
        idx     = 0;
        any_req = 1'b0;
        winner  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NCH)
                idx = idx - NCH;
            if (bus.req_valid[idx]) begin
                any_req = 1'b1;
                winner  = CHW'(idx);
            end
        end
    end

    assign grant    = (state == IDLE) && any_req;
    assign last_bit = (bit_idx == CW'(W - 1));

    always_comb begin
        grant_vec = '0;
        if (grant)
            grant_vec[winner] = 1'b1;
    end

    seqdet_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (grant),
        .en  (state == SHIFT),
        .x   (word[W-1]),
        .y   (core_y)
    );

    // Controller: grant in IDLE, stream W bits MSB-first, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            word       <= '0;
            bit_idx    <= '0;
            cnt        <= '0;
            resp_ch    <= '0;
            resp_count <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        word    <= bus.req_data[winner*W +: W];
                        resp_ch <= winner;
                        cnt     <= '0;
                        bit_idx <= '0;
                        rr_ptr  <= (winner == CHW'(NCH - 1)) ? '0 : winner + CHW'(1);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    word    <= {word[W-2:0], 1'b0};
                    cnt     <= cnt + CW'(core_y);
                    bit_idx <= bit_idx + CW'(1);
                    if (last_bit) begin
                        resp_count <= cnt + CW'(core_y);
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = grant_vec;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_ch    = resp_ch;
    assign bus.resp_count = resp_count;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_seqdet_rr_scheduler.sv
// Directed self-checking bench for seqdet_rr_scheduler (NCH=4, W=8).
module tb_seqdet_rr_scheduler;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seqdet_rr_scheduler_if #(.NCH(NCH), .W(W)) bus ();

    seqdet_rr_scheduler #(.NCH(NCH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] valid, input logic rdy);
        bus.req_valid  = valid;
        bus.resp_ready = rdy;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tag, "_ch"},    32'(bus.resp_ch),    32'd0);
        checkOutput({tag, "_count"}, 32'(bus.resp_count), 32'd0);
        checkOutput({tag, "_busy"},  32'(bus.busy),       32'd0);
        checkOutput({tag, "_ready"}, 32'(bus.req_ready),  32'd0);
    endtask

    // One isolated job on a single channel with resp_ready held high.
    task automatic runJob(input int ch, input logic [7:0] data, input int expCount);
        bus.req_data = '0;
        bus.req_data[ch*W +: W] = data;
        applyStimulus(NCH'(1 << ch), 1'b1);
        #1;
        checkOutput("job_grant", 32'(bus.req_ready), 32'(1 << ch));
        tick();
        applyStimulus('0, 1'b1);
        checkOutput("job_busy", 32'(bus.busy), 32'd1);
        checkOutput("job_ready_off", 32'(bus.req_ready), 32'd0);
        repeat (W - 1) begin
            tick();
            checkOutput("job_early_valid", 32'(bus.resp_valid), 32'd0);
        end
        tick();
        checkOutput("job_resp_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("job_resp_ch",    32'(bus.resp_ch),    32'(ch));
        checkOutput("job_resp_count", 32'(bus.resp_count), 32'(expCount));
        tick();
        checkOutput("job_resp_drop", 32'(bus.resp_valid), 32'd0);
        checkOutput("job_busy_drop", 32'(bus.busy),       32'd0);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_data = '0;
        applyStimulus('0, 1'b0);

        tick();
        tick();
        checkIdleOutputs("reset");
        rst = 1'b0;
        tick();
        checkIdleOutputs("post_reset");

        runJob(0, 8'hA6, 3);
        runJob(1, 8'hAA, 4);
        runJob(2, 8'h55, 3);
        runJob(3, 8'hFF, 0);
        runJob(0, 8'h00, 0);

        // All channels requesting continuously from reset.
        bus.req_data = {4{8'hA6}};
        applyStimulus(4'hF, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int g = 0; g < 5; g++) begin
            checkOutput("rr_grant", 32'(bus.req_ready), 32'(1 << order[g]));
            checkOutput("rr_onehot", 32'($countones(bus.req_ready)), 32'd1);
            tick();
            checkOutput("rr_ready_off", 32'(bus.req_ready), 32'd0);
            repeat (W) tick();
            checkOutput("rr_resp_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("rr_resp_ch",    32'(bus.resp_ch),    32'(order[g]));
            checkOutput("rr_resp_count", 32'(bus.resp_count), 32'd3);
            tick();
        end

        // Pointer wrap: after ch2 wins, ch3 must beat ch1.
        applyStimulus(4'b0100, 1'b1);
        #1;
        checkOutput("wrap_grant2", 32'(bus.req_ready), 32'b0100);
        tick();
        applyStimulus(4'b1010, 1'b1);
        repeat (W + 1) tick();
        checkOutput("wrap_grant3", 32'(bus.req_ready), 32'b1000);
        tick();
        repeat (W + 1) tick();
        checkOutput("wrap_grant1", 32'(bus.req_ready), 32'b0010);
        tick();
        applyStimulus('0, 1'b0);

        // Consumer stall: result held, no grants while waiting.
        repeat (W) tick();
        checkOutput("stall_valid_on", 32'(bus.resp_valid), 32'd1);
        applyStimulus(4'hF, 1'b0);
        repeat (5) begin
            tick();
            checkOutput("stall_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("stall_ch",    32'(bus.resp_ch),    32'd1);
            checkOutput("stall_count", 32'(bus.resp_count), 32'd3);
            checkOutput("stall_ready", 32'(bus.req_ready),  32'd0);
        end
        applyStimulus(4'hF, 1'b1);
        tick();
        checkOutput("stall_release", 32'(bus.resp_valid), 32'd0);
        checkOutput("stall_next_grant", 32'(bus.req_ready), 32'b0100);
        applyStimulus('0, 1'b1);
        #1;
        checkOutput("stall_no_grant", 32'(bus.req_ready), 32'd0);

        // Reset during SHIFT cycle 4 aborts the job silently.
        bus.req_data = {4{8'hAA}};
        applyStimulus(4'b0001, 1'b1);
        #1;
        checkOutput("abort_grant", 32'(bus.req_ready), 32'b0001);
        tick();
        applyStimulus('0, 1'b1);
        repeat (4) tick();
        checkOutput("abort_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        checkIdleOutputs("abort_async");
        tick();
        checkIdleOutputs("abort_next");
        rst = 1'b0;
        repeat (W + 3) begin
            tick();
            checkOutput("abort_no_resp", 32'(bus.resp_valid), 32'd0);
            checkOutput("abort_no_busy", 32'(bus.busy),       32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
